uart_rx_frontend: RTL and testbench
===================================

Name: uart_rx_frontend

Overview:
- RS-232 receive front end on the 16x oversample clock (rcvbuf_clk).
- Deserialises the rxd line into an 8-bit receive buffer (rbr) and raises newdata, which the downstream 10K-bit receive buffer edge-detects and serialises into the communications loopback.
- Flags framing errors (bad stop bit) and overruns (new byte completes before the previous newdata pulse has ended).

Parameters:
- OVERSAMPLE, 16: rcvbuf_clk ticks per bit; even, at least 4.
- NEWDATA_HOLD, 32: rcvbuf_clk cycles newdata stays high per byte. Must cover at least two clk_1200 edges' worth of detection margin downstream.

Ports:
- rcvbuf_clk, input, 1: 16x bit-rate clock; the only clock.
- rst_n, input, 1: asynchronous active-low reset.
- rxd, input, 1: asynchronous serial line; idles high.
- rbr, output, 8: last correctly framed byte, LSB = first bit received.
- newdata, output, 1: level pulse announcing a new rbr.
- framing_err, output, 1: one-cycle pulse on a bad stop bit.
- overrun_err, output, 1: one-cycle pulse when rbr is overwritten while newdata is high.

Behaviour:
- Clocking and reset:
  - One clock (rcvbuf_clk); reset is asynchronous, active-low (rst_n).
  - Reset values: rbr=8'h00, newdata=0, framing_err=0, overrun_err=0, FSM=IDLE, all counters 0, synchroniser flops=1.
- Input synchroniser: rxd passes through a 2-flop synchroniser (rxd_s). All decisions use rxd_s.
- Timing reference: cycle 0 is the first rising edge at which IDLE sees rxd_s=0.
- FSM states: IDLE, START, DATA, STOP, BRK_WAIT.
  - IDLE: on rxd_s=0, go to START and clear the tick counter.
  - START: at tick OVERSAMPLE/2 (cycle 8):
    - rxd_s=0: go to DATA with tick=0, bit=0.
    - rxd_s=1: false start; return to IDLE with no outputs changed.
  - DATA:
    - Every OVERSAMPLE ticks, shift rxd_s into a shift register, LSB first.
    - Data bit i is sampled at cycle 8+16(i+1).
    - After bit 7, go to STOP.
  - STOP: sample at cycle 152.
    - rxd_s=1: go to IDLE. rbr loads the shift register on the next edge; newdata goes high from cycle 153.
    - rxd_s=0: framing_err=1 for one cycle; rbr and newdata unchanged; go to BRK_WAIT.
  - BRK_WAIT: wait for rxd_s=1, then go to IDLE. Break conditions never retrigger.
  - The return to IDLE happens mid-stop-bit. A start edge arriving half a bit later is therefore caught, which gives back-to-back frames with no gap.
- newdata:
  - Held high exactly NEWDATA_HOLD cycles, counted by a hold counter, then low.
  - Never high for fewer than NEWDATA_HOLD cycles unless an overrun or a reset occurs.
- Overrun (valid stop while newdata=1):
  - rbr takes the new byte.
  - overrun_err=1 for one cycle.
  - newdata drops low for exactly one cycle, then rises again with a fresh NEWDATA_HOLD count. This guarantees a new rising edge downstream.
- Simultaneous events: if the hold counter expires on the same cycle as a valid stop, the valid stop wins and the overrun path does not apply. newdata stays low one cycle and then rises. overrun_err=0.
- Reset mid-frame: everything returns immediately to reset values; a partial byte is discarded.
- Counters:
  - Tick counter width is clog2(OVERSAMPLE); it wraps at OVERSAMPLE-1.
  - Hold counter width is clog2(NEWDATA_HOLD+1); it saturates at 0.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - An even-parity bit follows bit 7 and is sampled at cycle 152; stop is sampled at cycle 168.
  - A parity mismatch with a good stop bit is treated exactly like a framing error: framing_err pulse, rbr held, newdata not raised. The FSM then returns to IDLE, not BRK_WAIT.
- When undefined: no parity logic; 8N1 framing only.

Test Plan:
- Reset: hold rst_n=0 mid-frame, release, idle rxd -> rbr=00, newdata=0, both error outputs 0. A following frame for 0xA5 is received correctly.
- Single byte: 8N1 frame 0x5A at 16 ticks/bit -> rbr=5A from cycle 153, newdata high for exactly 32 cycles, no error pulses.
- False start: rxd low for 4 ticks, then high -> FSM back to IDLE, no newdata, rbr unchanged. A subsequent frame 0x3C is received correctly.
- Framing error: frame 0xFF with stop bit 0, then line held low for 40 bits, then 0x11 -> framing_err pulses once, rbr stays at the prior value, no retrigger during the break, then rbr=11 with newdata.
- Overrun: NEWDATA_HOLD=400, back-to-back frames 0x01 then 0x02 -> second stop gives overrun_err one cycle, newdata low one cycle then high for 400, rbr=02.
- Parity (UART_RX_PARITY_EN): 0x07 with parity 1 is accepted; 0x07 with parity 0 -> framing_err pulse and no newdata.

Source files
------------

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: RS-232 receive front end clocked by the 16x oversample clock.
// Deserialises rxd into rbr, announces each byte with a held newdata level and
// pulses framing_err / overrun_err.
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit after bit 7;
// a parity mismatch is reported as a framing error.
module uart_rx_frontend #(
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned NEWDATA_HOLD = 32
) (
  input  logic       rcvbuf_clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rbr,
  output logic       newdata,
  output logic       framing_err,
  output logic       overrun_err
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned HoldW = $clog2(NEWDATA_HOLD + 1);

  // Tick value seen at the edge that samples the middle of the start bit.
  localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [HoldW-1:0] HoldInit = HoldW'(NEWDATA_HOLD);
  localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBrkWait
  } state_e;

  state_e state_q, state_d;

  logic             sync_q;
  logic             rxd_s;
  logic [TickW-1:0] tick_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic [7:0]       rbr_q;
  logic             newdata_q;
  logic [HoldW-1:0] hold_q;
  logic             load_q;
  logic             framing_q;
  logic             overrun_q;

  // Control strobes decoded from the current state.
  logic tick_done;
  logic tick_clr;
  logic shift_en;
  logic stop_good;
  logic frame_bad;
  logic parity_bad;

  assign tick_done = (tick_q == TickLast);

`ifdef UART_RX_PARITY_EN
  logic par_q;
  logic par_en;

  // Parity bit captured mid-bit, checked together with the data at the stop sample.
  always_ff @(posedge rcvbuf_clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (par_en) begin
      par_q <= rxd_s;
    end
  end

  // Even parity: data plus parity bit must contain an even number of ones.
  assign parity_bad = ^{shift_q, par_q};
`else
  assign parity_bad = 1'b0;
`endif

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge rcvbuf_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b1;
      rxd_s  <= 1'b1;
    end else begin
      sync_q <= rxd;
      rxd_s  <= sync_q;
    end
  end

  // FSM state register.
  always_ff @(posedge rcvbuf_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (!rxd_s) state_d = StStart;
      end
      StStart: begin
        // A line that has returned high by mid start bit was a glitch.
        if (tick_q == TickHalf) state_d = rxd_s ? StIdle : StData;
      end
      StData: begin
`ifdef UART_RX_PARITY_EN
        if (tick_done && (bit_q == 3'd7)) state_d = StParity;
`else
        if (tick_done && (bit_q == 3'd7)) state_d = StStop;
`endif
      end
      StParity: begin
        if (tick_done) state_d = StStop;
      end
      StStop: begin
        // Leaving mid stop bit lets a back-to-back start edge be caught.
        if (tick_done) state_d = rxd_s ? StIdle : StBrkWait;
      end
      StBrkWait: begin
        if (rxd_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM output decode: datapath strobes for the current state.
  always_comb begin
    tick_clr  = 1'b0;
    shift_en  = 1'b0;
    stop_good = 1'b0;
    frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    case (state_q)
      StIdle:    tick_clr = 1'b1;
      StStart:   tick_clr = (tick_q == TickHalf);
      StData:    shift_en = tick_done;
`ifdef UART_RX_PARITY_EN
      StParity:  par_en   = tick_done;
`endif
      StStop: begin
        if (tick_done) begin
          stop_good = rxd_s & ~parity_bad;
          frame_bad = ~rxd_s | parity_bad;
        end
      end
      StBrkWait: tick_clr = 1'b1;
      default:   tick_clr = 1'b1;
    endcase
  end

  // Bit-timing tick counter, bit index and LSB-first shift register.
  always_ff @(posedge rcvbuf_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      if (tick_clr || tick_done) begin
        tick_q <= '0;
      end else begin
        tick_q <= tick_q + 1'b1;
      end
      if (tick_clr) begin
        bit_q <= 3'd0;
      end else if (shift_en) begin
        bit_q <= bit_q + 3'd1;
      end
      if (shift_en) begin
        shift_q <= {rxd_s, shift_q[7:1]};
      end
    end
  end

  // Receive buffer, newdata hold counter and error pulses.
  always_ff @(posedge rcvbuf_clk or negedge rst_n) begin
    if (!rst_n) begin
      rbr_q     <= 8'h00;
      newdata_q <= 1'b0;
      hold_q    <= '0;
      load_q    <= 1'b0;
      framing_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      load_q    <= stop_good;
      framing_q <= frame_bad;
      // A hold counter expiring on this very edge is a normal end, not an overrun.
      overrun_q <= stop_good & newdata_q & (hold_q != HoldOne);
      if (load_q) begin
        rbr_q     <= shift_q;
        newdata_q <= 1'b1;
        hold_q    <= HoldInit;
      end else if (stop_good && newdata_q) begin
        // Force one low cycle so downstream sees a fresh rising edge.
        newdata_q <= 1'b0;
        hold_q    <= '0;
      end else if (hold_q != '0) begin
        hold_q <= hold_q - 1'b1;
        if (hold_q == HoldOne) newdata_q <= 1'b0;
      end
    end
  end

  assign rbr         = rbr_q;
  assign newdata     = newdata_q;
  assign framing_err = framing_q;
  assign overrun_err = overrun_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: directed frames plus random bytes
// compared against a frame-level reference model. Instance a uses the default
// hold time, instance b a long hold time for the overrun case.
module tb_uart_rx_frontend;

`ifdef UART_RX_PARITY_EN
  localparam int FrameBits = 11;
  localparam int NdLat     = 172;
`else
  localparam int FrameBits = 10;
  localparam int NdLat     = 156;
`endif

  logic       clk;
  logic       rst_n;
  logic       rxd_a, rxd_b;
  logic [7:0] rbr_a, rbr_b;
  logic       newdata_a, newdata_b;
  logic       framing_err_a, framing_err_b;
  logic       overrun_err_a, overrun_err_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Event monitors, sampled on the falling edge.
  int         rise_cnt_a = 0, rise_cyc_a = 0, run_a = 0, last_len_a = 0, fe_a = 0, oe_a = 0;
  logic       nd_prev_a = 1'b0;
  logic [7:0] rise_rbr_a = 8'h00;
  int         rise_cnt_b = 0, rise_cyc_b = 0, run_b = 0, last_len_b = 0, fe_b = 0, oe_b = 0;
  int         low_b = 0, last_gap_b = 0;
  logic       nd_prev_b = 1'b0;
  logic [7:0] rise_rbr_b = 8'h00;

  uart_rx_frontend dut_a (
    .rcvbuf_clk  (clk),
    .rst_n       (rst_n),
    .rxd         (rxd_a),
    .rbr         (rbr_a),
    .newdata     (newdata_a),
    .framing_err (framing_err_a),
    .overrun_err (overrun_err_a)
  );

  uart_rx_frontend #(
    .OVERSAMPLE   (16),
    .NEWDATA_HOLD (400)
  ) dut_b (
    .rcvbuf_clk  (clk),
    .rst_n       (rst_n),
    .rxd         (rxd_b),
    .rbr         (rbr_b),
    .newdata     (newdata_b),
    .framing_err (framing_err_b),
    .overrun_err (overrun_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    nd_prev_a <= newdata_a;
    run_a     <= newdata_a ? run_a + 1 : 0;
    if (newdata_a && !nd_prev_a) begin
      rise_cnt_a <= rise_cnt_a + 1;
      rise_cyc_a <= cyc;
      rise_rbr_a <= rbr_a;
    end
    if (!newdata_a && nd_prev_a) last_len_a <= run_a;
    if (framing_err_a) fe_a <= fe_a + 1;
    if (overrun_err_a) oe_a <= oe_a + 1;
  end

  always @(negedge clk) begin
    nd_prev_b <= newdata_b;
    run_b     <= newdata_b ? run_b + 1 : 0;
    low_b     <= newdata_b ? 0 : low_b + 1;
    if (newdata_b && !nd_prev_b) begin
      rise_cnt_b <= rise_cnt_b + 1;
      rise_cyc_b <= cyc;
      rise_rbr_b <= rbr_b;
      last_gap_b <= low_b;
    end
    if (!newdata_b && nd_prev_b) last_len_b <= run_b;
    if (framing_err_b) fe_b <= fe_b + 1;
    if (overrun_err_b) oe_b <= oe_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every wait ends 1 time unit after a rising edge.
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame bits LSB first: start, data, [even parity], stop.
  function automatic logic [15:0] frame(input logic [7:0] b, input logic stop_bit);
`ifdef UART_RX_PARITY_EN
    frame = {5'b0, stop_bit, ^b, b, 1'b0};
`else
    frame = {6'b0, stop_bit, b, 1'b0};
`endif
  endfunction

  task automatic send(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rxd_a = bits[i];
      else          rxd_b = bits[i];
      wait_cycles(16);
    end
  endtask

  initial begin
    int         e;
    int         exp_rise;
    int         exp_fe;
    logic [7:0] exp_rbr;
    logic [7:0] b;
    logic       good;

    rst_n = 1'b0;
    rxd_a = 1'b1;
    rxd_b = 1'b1;
    @(posedge clk);
    #1;
    wait_cycles(3);
    check("rst_rbr_during", rbr_a, 8'h00);
    check("rst_nd_during", newdata_a, 1'b0);
    rst_n = 1'b1;
    wait_cycles(5);
    check("rst_rbr", rbr_a, 8'h00);
    check("rst_nd", newdata_a, 1'b0);
    check("rst_fe", framing_err_a, 1'b0);
    check("rst_oe", overrun_err_a, 1'b0);

    // Single byte 0x5A.
    e = cyc;
    send(0, frame(8'h5A, 1'b1), FrameBits);
    rxd_a = 1'b1;
    wait_cycles(60);
    check("single_rises", rise_cnt_a, 1);
    check("single_rbr_at_rise", rise_rbr_a, 8'h5A);
    check("single_latency", rise_cyc_a, e + NdLat);
    check("single_nd_len", last_len_a, 32);
    check("single_rbr", rbr_a, 8'h5A);
    check("single_fe", fe_a, 0);

    // Reset in the middle of a frame.
    rxd_a = 1'b0;
    wait_cycles(50);
    rst_n = 1'b0;
    rxd_a = 1'b1;
    wait_cycles(1);
    check("midrst_rbr_during", rbr_a, 8'h00);
    wait_cycles(4);
    rst_n = 1'b1;
    wait_cycles(200);
    check("midrst_rbr", rbr_a, 8'h00);
    check("midrst_nd", newdata_a, 1'b0);
    check("midrst_rises", rise_cnt_a, 1);
    check("midrst_fe", fe_a, 0);
    send(0, frame(8'hA5, 1'b1), FrameBits);
    rxd_a = 1'b1;
    wait_cycles(60);
    check("after_rst_rises", rise_cnt_a, 2);
    check("after_rst_rbr", rise_rbr_a, 8'hA5);

    // False start: 4 ticks low.
    rxd_a = 1'b0;
    wait_cycles(4);
    rxd_a = 1'b1;
    wait_cycles(200);
    check("false_rises", rise_cnt_a, 2);
    check("false_rbr", rbr_a, 8'hA5);
    check("false_fe", fe_a, 0);
    e = cyc;
    send(0, frame(8'h3C, 1'b1), FrameBits);
    rxd_a = 1'b1;
    wait_cycles(60);
    check("after_false_rises", rise_cnt_a, 3);
    check("after_false_rbr", rise_rbr_a, 8'h3C);
    check("after_false_latency", rise_cyc_a, e + NdLat);

    // Framing error then a 40-bit break.
    send(0, frame(8'hFF, 1'b0), FrameBits);
    wait_cycles(40 * 16);
    check("brk_fe", fe_a, 1);
    check("brk_rises", rise_cnt_a, 3);
    check("brk_rbr", rbr_a, 8'h3C);
    rxd_a = 1'b1;
    wait_cycles(32);
    send(0, frame(8'h11, 1'b1), FrameBits);
    rxd_a = 1'b1;
    wait_cycles(60);
    check("after_brk_rises", rise_cnt_a, 4);
    check("after_brk_rbr", rise_rbr_a, 8'h11);
    check("after_brk_fe", fe_a, 1);

    // Random bytes against the frame-level model.
    exp_rise = 4;
    exp_fe   = 1;
    exp_rbr  = 8'h11;
    for (int k = 0; k < 8; k++) begin
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      send(0, frame(b, good), FrameBits);
      rxd_a = 1'b1;
      wait_cycles(40 + $urandom_range(0, 20));
      if (good) begin
        exp_rbr = b;
        exp_rise++;
        check("rand_rbr_at_rise", rise_rbr_a, b);
        check("rand_nd_len", last_len_a, 32);
      end else begin
        exp_fe++;
      end
      check("rand_rbr", rbr_a, exp_rbr);
      check("rand_rises", rise_cnt_a, exp_rise);
      check("rand_fe", fe_a, exp_fe);
    end
    check("a_no_overrun", oe_a, 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: parity 1 is good, parity 0 is bad.
    send(0, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    rxd_a = 1'b1;
    wait_cycles(60);
    check("par_ok_rises", rise_cnt_a, exp_rise + 1);
    check("par_ok_rbr", rbr_a, 8'h07);
    send(0, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    rxd_a = 1'b1;
    wait_cycles(60);
    check("par_bad_fe", fe_a, exp_fe + 1);
    check("par_bad_rises", rise_cnt_a, exp_rise + 1);
    check("par_bad_rbr", rbr_a, 8'h07);
`endif

    // Overrun with the long hold instance: back-to-back frames.
    send(1, frame(8'h01, 1'b1), FrameBits);
    check("ovr_first_rises", rise_cnt_b, 1);
    check("ovr_first_rbr", rise_rbr_b, 8'h01);
    e = cyc;
    send(1, frame(8'h02, 1'b1), FrameBits);
    rxd_b = 1'b1;
    wait_cycles(450);
    check("ovr_oe", oe_b, 1);
    check("ovr_rises", rise_cnt_b, 2);
    check("ovr_latency", rise_cyc_b, e + NdLat);
    check("ovr_gap", last_gap_b, 1);
    check("ovr_nd_len", last_len_b, 400);
    check("ovr_rbr", rbr_b, 8'h02);
    check("ovr_fe", fe_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
